// File: rtl/mux_arb_rr.sv
// N:1 channel multiplexer with registered output, valid/ready handshakes and
// run-time choice of direct select or round-robin arbitration. Optional stall counter: MUX_ARB_STALL_CNT_EN.
module mux_arb_rr #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          s,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_ARB_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  logic [SEL_W-1:0] last_p1;
  logic [SEL_W-1:0] gnt_p0;
  logic             gnt_ok_p0;
  logic             can_accept_p0;
  logic             xfer_p0;
  logic [WIDTH-1:0] sel_data_p0;
  logic [SEL_W:0]   rr_res_p0;
  logic [CHANNELS-1:0] dir_vld_p0;

  // Returns {found, index} of the first valid channel after ptr, wrapping.
  function automatic logic [SEL_W:0] rr_pick(input logic [CHANNELS-1:0] vld,
                                             input logic [SEL_W-1:0]    ptr);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [CHANNELS-1:0] sh;
    int               c;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      c = int'(ptr) + off;
      if (c >= CHANNELS) c = c - CHANNELS;
      sh = vld >> c;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = SEL_W'(c);
      end
    end
    return {found, idx};
  endfunction

  // Stage p0: combinational grant and input handshake
  assign can_accept_p0 = !out_valid || out_ready;
  assign rr_res_p0     = rr_pick(in_valid, last_p1);
  assign dir_vld_p0    = in_valid >> s;

  always_comb begin
    gnt_p0    = '0;
    gnt_ok_p0 = 1'b0;
    if (mode) begin
      gnt_p0    = rr_res_p0[SEL_W-1:0];
      gnt_ok_p0 = rr_res_p0[SEL_W];
    end else if (int'(s) < CHANNELS) begin
      gnt_p0    = s;
      gnt_ok_p0 = dir_vld_p0[0];
    end
  end

  assign in_ready    = (gnt_ok_p0 && can_accept_p0) ? (CHANNELS'(1) << gnt_p0) : '0;
  assign xfer_p0     = gnt_ok_p0 && can_accept_p0;
  assign sel_data_p0 = WIDTH'(in_data >> (int'(gnt_p0) * WIDTH));

  // Stage p1: single-entry output buffer and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer_p0) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_p0;
      out_chan  <= gnt_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p1 <= SEL_W'(CHANNELS - 1);
    end else if (xfer_p0 && mode) begin
      last_p1 <= gnt_p0;
    end
  end

`ifdef MUX_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
